// File: rtl/sprite_compositor.sv
// sprite_compositor: merges the per-layer sprite pixels with a background
// index. The lowest-numbered drawing layer wins. The winning index goes
// through a writable palette, and the result drives registered VGA outputs
// with sync and blank delayed to match. Optionally it also accumulates
// per-frame sprite-overlap flags.
//
// Optional feature macro: SPRITE_COMPOSITOR_COLLISION_EN
//   Defined   : overlap accumulator with collide/collide_valid outputs.
//   Undefined : collide and collide_valid are tied to 0.
//
// Ports:
//   clk, rst         pixel clock, synchronous active-high reset
//   frame            one-cycle start-of-frame pulse
//   de_in/hs_in/vs_in display enable and syncs, aligned with layer inputs
//   layer_pix        layer i index at [i*COLR_BITS +: COLR_BITS]
//   layer_drawing    layer i is drawing an opaque pixel
//   bg_colr          background index
//   pal_we/addr/data palette write port, data is {R,G,B}
//   vga_r/g/b        output colour (0 while blanked)
//   vga_hs/vs/de     syncs and enable, delayed 3 cycles
//   collide          per-layer overlap flags for the previous frame
//   collide_valid    one-cycle pulse when collide updates
module sprite_compositor #(
  parameter int unsigned LAYERS    = 4,
  parameter int unsigned COLR_BITS = 4,
  parameter int unsigned CHAN_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame,
  input  logic                          de_in,
  input  logic                          hs_in,
  input  logic                          vs_in,
  input  logic [LAYERS*COLR_BITS-1:0]   layer_pix,
  input  logic [LAYERS-1:0]             layer_drawing,
  input  logic [COLR_BITS-1:0]          bg_colr,
  input  logic                          pal_we,
  input  logic [COLR_BITS-1:0]          pal_addr,
  input  logic [3*CHAN_BITS-1:0]        pal_data,
  output logic [CHAN_BITS-1:0]          vga_r,
  output logic [CHAN_BITS-1:0]          vga_g,
  output logic [CHAN_BITS-1:0]          vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          vga_de,
  output logic [LAYERS-1:0]             collide,
  output logic                          collide_valid
);

  localparam int unsigned RGB_BITS  = 3 * CHAN_BITS;
  localparam int unsigned PAL_DEPTH = 1 << COLR_BITS;

  logic [COLR_BITS-1:0] sel_idx_c;
  logic [COLR_BITS-1:0] idx1;
  logic                 de1, hs1, vs1;
  logic [RGB_BITS-1:0]  rgb2;
  logic                 de2, hs2, vs2;
  logic [RGB_BITS-1:0]  pal [PAL_DEPTH];

  // Priority select: scan from the highest layer down so layer 0 wins last.
  always_comb begin
    sel_idx_c = bg_colr;
    for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
      if (layer_drawing[i]) sel_idx_c = layer_pix[i*COLR_BITS +: COLR_BITS];
    end
  end

  // Palette: reset to a grey ramp. The lookup in stage 2 sees the pre-write
  // value on a same-cycle write to the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
        pal[i] <= {3{CHAN_BITS'(i)}};
      end
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Three-stage pixel pipeline: select, lookup, output.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx1   <= '0;
      de1    <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      rgb2   <= '0;
      de2    <= 1'b0;
      hs2    <= 1'b0;
      vs2    <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else begin
      idx1   <= sel_idx_c;
      de1    <= de_in;
      hs1    <= hs_in;
      vs1    <= vs_in;
      rgb2   <= pal[idx1];
      de2    <= de1;
      hs2    <= hs1;
      vs2    <= vs1;
      vga_r  <= de2 ? rgb2[RGB_BITS-1 -: CHAN_BITS]   : '0;
      vga_g  <= de2 ? rgb2[2*CHAN_BITS-1 -: CHAN_BITS] : '0;
      vga_b  <= de2 ? rgb2[CHAN_BITS-1:0]             : '0;
      vga_hs <= hs2;
      vga_vs <= vs2;
      vga_de <= de2;
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  logic [LAYERS-1:0] acc;
  logic [LAYERS-1:0] hit_c;

  // Two or more bits set means clearing the lowest set bit leaves a nonzero
  // value. In that case every drawing layer has overlapped another.
  always_comb begin
    hit_c = '0;
    if (de_in && (|(layer_drawing & (layer_drawing - LAYERS'(1))))) begin
      hit_c = layer_drawing;
    end
  end

  // On frame, publish this frame's flags, including the current cycle, and
  // start the next frame clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      collide       <= '0;
      collide_valid <= 1'b0;
    end else if (frame) begin
      collide       <= acc | hit_c;
      collide_valid <= 1'b1;
      acc           <= '0;
    end else begin
      acc           <= acc | hit_c;
      collide_valid <= 1'b0;
    end
  end
`else
  logic unused_frame;
  assign unused_frame  = frame;
  assign collide       = '0;
  assign collide_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor. A vector table is streamed
// through the pixel pipeline. Hand-written sequences then cover palette
// write hazards, overlap accumulation and reset mid-frame.
module tb_sprite_compositor;

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        de_in, hs_in, vs_in;
  logic [15:0] layer_pix;
  logic [3:0]  layer_drawing;
  logic [3:0]  bg_colr;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de;
  logic [3:0]  collide;
  logic        collide_valid;

  int n_cmp = 0;
  int n_err = 0;

  sprite_compositor #(.LAYERS(4), .COLR_BITS(4), .CHAN_BITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame         (frame),
    .de_in         (de_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .layer_pix     (layer_pix),
    .layer_drawing (layer_drawing),
    .bg_colr       (bg_colr),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_data      (pal_data),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_de        (vga_de),
    .collide       (collide),
    .collide_valid (collide_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        de, hs, vs;
    logic [3:0]  drw;
    logic [15:0] pix;
    logic [3:0]  bg;
    logic [11:0] exp_rgb;
    logic [2:0]  exp_dhv;   // {de,hs,vs}
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [3:0] drw, input logic [15:0] pix,
                       input logic [3:0] bg);
    de_in = de; hs_in = hs; vs_in = vs;
    layer_drawing = drw; layer_pix = pix; bg_colr = bg;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vga_pack();
    return 32'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs});
  endfunction

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd5, 12'h555, 3'b100};
    vt[1] = '{1'b1, 1'b0, 1'b0, 4'b1010, 16'h2090, 4'd5, 12'h999, 3'b100};
    vt[2] = '{1'b1, 1'b0, 1'b0, 4'b1000, 16'h2090, 4'd5, 12'h222, 3'b100};
    vt[3] = '{1'b0, 1'b1, 1'b1, 4'b0001, 16'h0007, 4'd5, 12'h000, 3'b011};
    vt[4] = '{1'b0, 1'b1, 1'b0, 4'b0001, 16'h0007, 4'd5, 12'h000, 3'b010};
    vt[5] = '{1'b1, 1'b0, 1'b0, 4'b1111, 16'hABCD, 4'd5, 12'hDDD, 3'b100};
    vt[6] = '{1'b1, 1'b0, 1'b0, 4'b0110, 16'h0E30, 4'd5, 12'h333, 3'b100};
    vt[7] = '{1'b1, 1'b0, 1'b0, 4'b0000, 16'h0E30, 4'hF, 12'hFFF, 3'b100};
    vt[8] = '{1'b1, 1'b0, 1'b1, 4'b0100, 16'h0030, 4'd5, 12'h000, 3'b101};

    // Reset with busy inputs
    rst = 1'b1; frame = 1'b0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    drive(1'b1, 1'b1, 1'b1, 4'b0011, 16'h1234, 4'd9);
    tick(); tick();
    check("reset_vga", vga_pack(), 32'h0);
    check("reset_collide", 32'({collide, collide_valid}), 32'h0);
    rst = 1'b0;

    // Streamed table: outputs lag inputs by 3 register stages
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drive(vt[i].de, vt[i].hs, vt[i].vs, vt[i].drw, vt[i].pix, vt[i].bg);
      else       drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0);
      tick();
      if (i >= 2)
        check($sformatf("vec%0d", i - 2), vga_pack(),
              32'({vt[i-2].exp_rgb, vt[i-2].exp_dhv}));
    end

    // First frame pulse publishes the table's overlaps (layers 0..3 all hit)
    frame = 1'b1; tick(); frame = 1'b0;
    check("tbl_collide", 32'({collide, collide_valid}),
          COLL ? 32'h1F : 32'h0);
    tick();
    check("tbl_valid_drop", 32'(collide_valid), 32'h0);

    // Palette write while index 9 sits in stage 1
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0009, 4'd0); tick();
    pal_we = 1'b1; pal_addr = 4'd9; pal_data = 12'hF00; tick();
    pal_we = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0); tick();
    check("pal_old", vga_pack(), 32'({12'h999, 3'b100}));
    tick();
    check("pal_new", vga_pack(), 32'({12'hF00, 3'b100}));
    tick();
    check("pal_blank", vga_pack(), 32'h0);

    // Overlap of layers 0 and 2 for one cycle; de=0 overlap is ignored
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0); tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0101, 16'h0000, 4'd0); tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 4'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'b1010, 16'h0000, 4'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0);
    frame = 1'b1; tick(); frame = 1'b0;
    check("ovl_0101", 32'({collide, collide_valid}), COLL ? 32'hB : 32'h0);
    tick();
    check("ovl_hold", 32'({collide, collide_valid}), COLL ? 32'hA : 32'h0);

    // Frame with no overlap clears collide
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 16'h0000, 4'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0);
    frame = 1'b1; tick(); frame = 1'b0;
    check("no_ovl", 32'({collide, collide_valid}), COLL ? 32'h1 : 32'h0);

    // Overlap on the frame cycle itself is latched, not carried forward
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 16'h0000, 4'd0);
    frame = 1'b1; tick(); frame = 1'b0;
    check("frame_ovl", 32'({collide, collide_valid}), COLL ? 32'h7 : 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0); tick();
    frame = 1'b1; tick(); frame = 1'b0;
    check("not_carried", 32'({collide, collide_valid}), COLL ? 32'h1 : 32'h0);

    // Leave a nonzero collide before the reset test
    drive(1'b1, 1'b0, 1'b0, 4'b1001, 16'h0000, 4'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0);
    frame = 1'b1; tick(); frame = 1'b0;
    check("ovl_1001", 32'({collide, collide_valid}), COLL ? 32'h13 : 32'h0);

    // Reset mid-frame after an overlap and a palette write
    drive(1'b1, 1'b0, 1'b0, 4'b0110, 16'h0000, 4'd0); tick();
    pal_we = 1'b1; pal_addr = 4'd3; pal_data = 12'h0F0;
    drive(1'b1, 1'b1, 1'b1, 4'b0001, 16'h0003, 4'd0); tick();
    pal_we = 1'b0; tick();
    rst = 1'b1; tick();
    check("rst_vga", vga_pack(), 32'h0);
    check("rst_collide", 32'({collide, collide_valid}), 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 4'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0); tick(); tick();
    check("rst_grey", vga_pack(), 32'({12'h333, 3'b100}));
    frame = 1'b1; tick(); frame = 1'b0;
    check("rst_acc_clr", 32'({collide, collide_valid}), COLL ? 32'h1 : 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Downstream stage of the sprite engines: merges the per-layer `pixel`/`drawing` outputs of up to LAYERS sprite instances with a background colour index, resolves priority, maps the winning 4-bit index through a writable palette to 12-bit RGB, and drives the VGA output registers with sync/blank delayed to match. It also accumulates per-frame sprite-overlap flags that game logic reads once per frame for hit detection.

## Interface
- LAYERS, 4, number of sprite layers; layer 0 is highest priority
- COLR_BITS, 4, colour-index width (matches sprite pixel width)
- CHAN_BITS, 4, bits per RGB channel; palette entry width is 3*CHAN_BITS

- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- frame  in  1  one-cycle pulse at start of each frame (from display timing)
- de_in, hs_in, vs_in  in  1 each  display-enable and syncs, aligned with the layer inputs
- layer_pix  in  LAYERS*COLR_BITS  layer i at bits [i*COLR_BITS +: COLR_BITS]
- layer_drawing  in  LAYERS  layer i is drawing a non-transparent pixel
- bg_colr  in  COLR_BITS  background index used when no layer draws
- pal_we  in  1  palette write strobe
- pal_addr  in  COLR_BITS  palette write address
- pal_data  in  3*CHAN_BITS  {R,G,B} write data
- vga_r, vga_g, vga_b  out  CHAN_BITS each  output colour
- vga_hs, vga_vs, vga_de  out  1 each  delayed syncs/enable
- collide  out  LAYERS  bit i set if layer i overlapped any other layer during the previous frame
- collide_valid  out  1  one-cycle pulse when collide updates

## Operation
- Stage 1 (select): index = layer_pix of the lowest-numbered layer with layer_drawing=1, else bg_colr; de/hs/vs registered alongside.
- Stage 2 (lookup): palette read of stage-1 index; palette is 2^COLR_BITS registers of 3*CHAN_BITS bits.
- Stage 3 (output): if delayed de=1 drive RGB from palette, else RGB=0; syncs pass through.
- Palette: reset contents entry i = {i,i,i} truncated/zero-extended to CHAN_BITS (grey ramp). Write on pal_we takes effect the next cycle; a lookup in the same cycle as a write to the same address returns the old value.
- Overlap: each cycle with de_in=1, any layer whose layer_drawing=1 while at least one other layer_drawing=1 sets its accumulator bit. layer_drawing ignored when de_in=0.
- On frame: collide <= accumulator (including the current-cycle contribution), collide_valid=1 for one cycle, accumulator cleared. A frame pulse with de_in=1 and overlap: that cycle's contribution is latched into collide, not carried into the new frame.
- rst mid-frame: pipeline flushed, accumulator cleared, palette returns to grey ramp.

## Timing
- Latency: layer inputs to vga_* = 3 cycles; vga_hs/vs/de delayed exactly 3 cycles from hs_in/vs_in/de_in.
- Throughput: one pixel per cycle, no stalls.
- Reset values: vga_r/g/b=0, vga_hs=0, vga_vs=0, vga_de=0, collide=0, collide_valid=0; all pipeline registers 0.
- collide_valid asserted the cycle after frame is sampled; collide stable until next frame.

## Configuration
- SPRITE_COMPOSITOR_COLLISION_EN defined: overlap accumulator, collide and collide_valid as above.
- Not defined: accumulator not built; collide tied 0, collide_valid tied 0; pixel path unaffected.

## Test plan
- Reset, no writes, de_in=1, no layers drawing, bg_colr=5 -> vga_rgb={5,5,5} 3 cycles later; vga_de follows de_in with 3-cycle delay.
- Layers 1 and 3 drawing indices 9 and 2 -> output is palette[9]; drop layer 1 -> palette[2] after 3 cycles.
- Write pal_addr=9, pal_data=12'hF00 while index 9 in stage 1 -> that pixel shows old {9,9,9}, next pixel shows F,0,0.
- de_in=0 with layer 0 drawing index 7 -> vga_rgb=0, hs/vs delayed 3 cycles unchanged.
- Layers 0 and 2 overlap for one de cycle mid-frame, then frame pulse -> collide=4'b0101, collide_valid one cycle; next frame without overlap -> collide=0.
- Assert rst mid-frame after an overlap and a palette write -> all outputs 0, palette back to grey ramp, next frame collide=0.
